// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin arbiter sharing one memory port between
// requester 0 (core load/store) and requester 1 (core fetch).
// Grants are combinational and at most one access issues per cycle.
// Read data returns one cycle after issue and is steered back to the issuer.
// A requester may lock the port for back-to-back beats.
// Optional build macro: MEM_ARB_PERF_EN adds saturating per-requester
// grant and stall counters together with the perf_grant/perf_stall ports.
module mem_port_arb #(
  parameter int MSB_MEM = 7,
  parameter int CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [1:0]               req_wr,
  input  logic [1:0]               req_lock,
  input  logic [1:0][MSB_MEM:2]    req_address,
  input  logic [1:0][31:0]         req_data,
  output logic [1:0]               req_ready,
  output logic [1:0]               rsp_valid,
  output logic [31:0]              rsp_data,
  output logic [MSB_MEM:2]         mem_address,
  output logic [31:0]              mem_data,
  output logic                     mem_rden,
  output logic                     mem_wren,
  input  logic [31:0]              mem_q
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [1:0][CNT_W-1:0]    perf_grant,
  output logic [1:0][CNT_W-1:0]    perf_stall
`endif
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t     state;
  logic       rr_ptr;
  logic [1:0] grant;
  logic       sel;
  logic       accepted;
  logic       rd_tag_vld;
  logic       rd_tag;

  // Grant selection from current requests, round-robin pointer and lock state
  always_comb begin
    grant = '0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (req_valid == 2'b11) grant[rr_ptr] = 1'b1;
          else                    grant = req_valid;
        end
        LOCK0:   grant[0] = req_valid[0];
        LOCK1:   grant[1] = req_valid[1];
        default: grant = '0;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign accepted  = |grant;

  // Memory port drive muxed from the granted requester, zero when idle
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (accepted) begin
      mem_address = req_address[sel];
      mem_data    = req_data[sel];
      mem_rden    = ~req_wr[sel];
      mem_wren    = req_wr[sel];
    end
  end

  // Arbitration state: round-robin pointer and lock ownership
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= ARB;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (accepted) begin
            rr_ptr <= ~sel;
            if (req_lock[sel]) state <= sel ? LOCK1 : LOCK0;
          end
        end
        // A valid owner is always granted while locked, so "owner dropped
        // valid" and "owner's beat ended the lock" merge into one test.
        LOCK0: begin
          if (!req_valid[0] || !req_lock[0]) begin
            state  <= ARB;
            rr_ptr <= 1'b1;
          end
        end
        LOCK1: begin
          if (!req_valid[1] || !req_lock[1]) begin
            state  <= ARB;
            rr_ptr <= 1'b0;
          end
        end
        default: begin
          state  <= ARB;
          rr_ptr <= 1'b0;
        end
      endcase
    end
  end

  // Read tag: remembers which requester owns the data arriving next cycle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_tag_vld <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      rd_tag_vld <= mem_rden;
      if (mem_rden) rd_tag <= sel;
    end
  end

  // Response steering: memory q goes only to the tagged requester
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rd_tag_vld) begin
      rsp_valid[rd_tag] = 1'b1;
      rsp_data          = mem_q;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating per-requester counters of accepted beats and stalled cycles
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      perf_grant <= '0;
      perf_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i] && (perf_grant[i] != '1))
          perf_grant[i] <= perf_grant[i] + CNT_W'(1);
        if (req_valid[i] && !grant[i] && (perf_stall[i] != '1))
          perf_stall[i] <= perf_stall[i] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: randomized and directed bench for mem_port_arb.
// A behavioural memory sits on the port; expectations come from an
// abstract model (owner/pointer integers, shadow memory array).
// Build with MEM_ARB_PERF_EN to also check the performance counters.
module tb_mem_port_arb;
  localparam int MSB_MEM = 7;
  localparam int CNT_W   = 16;
  localparam int AW      = MSB_MEM - 1;
  localparam int DEPTH   = 1 << AW;

  logic                  clock = 1'b0;
  logic                  rst   = 1'b1;
  logic [1:0]            req_valid;
  logic [1:0]            req_wr;
  logic [1:0]            req_lock;
  logic [1:0][AW-1:0]    req_address;
  logic [1:0][31:0]      req_data;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;
  logic [31:0]           rsp_data;
  logic [AW-1:0]         mem_address;
  logic [31:0]           mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [31:0]           mem_q;
`ifdef MEM_ARB_PERF_EN
  logic [1:0][CNT_W-1:0] perf_grant;
  logic [1:0][CNT_W-1:0] perf_stall;
`endif

  always #5 clock = ~clock;

  mem_port_arb #(.MSB_MEM(MSB_MEM), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_lock    (req_lock),
    .req_address (req_address),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_grant  (perf_grant),
    .perf_stall  (perf_stall)
`endif
  );

  // Behavioural memory with registered read data
  logic [31:0] stub_mem [DEPTH];
  logic        init_mem = 1'b1;

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'hA500_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) stub_mem[i] <= init_val(i);
    end else begin
      if (mem_wren) stub_mem[mem_address] <= mem_data;
      if (mem_rden) mem_q <= stub_mem[mem_address];
    end
  end

  // Reference model state
  int          m_rr;
  int          m_owner;
  logic [31:0] shadow [DEPTH];
  bit          exp_vld;
  int          exp_who;
  logic [31:0] exp_dat;
  int unsigned m_pg [2];
  int unsigned m_ps [2];
  bit          stalled [2];

  int unsigned n_vec;
  int unsigned n_err;

  logic [1:0]  cap_ready;
  logic [1:0]  cap_rv;
  logic [31:0] cap_rd;
  logic        cap_rden;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rr    = 0;
    m_owner = -1;
    exp_vld = 1'b0;
    exp_who = 0;
    exp_dat = '0;
    for (int i = 0; i < 2; i++) begin
      m_pg[i]    = 0;
      m_ps[i]    = 0;
      stalled[i] = 1'b0;
    end
  endfunction

  // Who should win this cycle, from the arbitration rules
  function automatic int model_pick();
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    if (req_valid == 2'b11) return m_rr;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  // Check one cycle against the model, then advance the model past the edge
  task automatic step();
    int          g;
    int          gi;
    logic [1:0]  eg;
    logic [1:0]  erv;
    #1;
    g   = model_pick();
    gi  = (g < 0) ? 0 : g;
    eg  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    erv = !exp_vld ? 2'b00 : ((exp_who == 0) ? 2'b01 : 2'b10);
    check("req_ready",   64'(req_ready),   64'(eg));
    check("mem_rden",    64'(mem_rden),    64'((g >= 0) && !req_wr[gi]));
    check("mem_wren",    64'(mem_wren),    64'((g >= 0) && req_wr[gi]));
    check("mem_address", 64'(mem_address), (g >= 0) ? 64'(req_address[gi]) : 64'(0));
    check("mem_data",    64'(mem_data),    (g >= 0) ? 64'(req_data[gi]) : 64'(0));
    check("rsp_valid",   64'(rsp_valid),   64'(erv));
    check("rsp_data",    64'(rsp_data),    exp_vld ? 64'(exp_dat) : 64'(0));
    cap_ready = req_ready;
    cap_rv    = rsp_valid;
    cap_rd    = rsp_data;
    cap_rden  = mem_rden;
    @(posedge clock);
    exp_vld = 1'b0;
    if (g >= 0) begin
      if (req_wr[g]) shadow[req_address[g]] = req_data[g];
      else begin
        exp_vld = 1'b1;
        exp_who = g;
        exp_dat = shadow[req_address[g]];
      end
    end
    for (int i = 0; i < 2; i++) begin
      stalled[i] = req_valid[i] && (g != i);
      if (g == i) m_pg[i]++;
      else if (req_valid[i]) m_ps[i]++;
    end
    if (m_owner >= 0) begin
      if (g < 0 || !req_lock[g]) begin
        m_rr    = 1 - m_owner;
        m_owner = -1;
      end
    end else if (g >= 0) begin
      m_rr = 1 - g;
      if (req_lock[g]) m_owner = g;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] lk,
                       input int a0, input int a1, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clock);
    req_valid      = v;
    req_wr         = wr;
    req_lock       = lk;
    req_address[0] = AW'(a0);
    req_address[1] = AW'(a1);
    req_data[0]    = d0;
    req_data[1]    = d1;
    step();
  endtask

  task automatic check_perf(input string tag);
`ifdef MEM_ARB_PERF_EN
    for (int i = 0; i < 2; i++) begin
      check({tag, "_perf_grant"}, 64'(perf_grant[i]), 64'(m_pg[i]));
      check({tag, "_perf_stall"}, 64'(perf_stall[i]), 64'(m_ps[i]));
    end
`else
    if (tag.len() == 0) $display("empty perf tag");
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst       = 1'b1;
    req_valid = 2'b00;
    #1;
    model_reset();
    check("rst_ready", 64'(req_ready), 64'(0));
    @(negedge clock);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    req_valid   = 2'b11;
    req_wr      = '0;
    req_lock    = '0;
    req_address = '0;
    req_data    = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    model_reset();

    // Reset values with both requesters asserting valid
    repeat (2) @(posedge clock);
    #2;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_mem_rden",  64'(mem_rden),  64'(0));
    check("rst_mem_wren",  64'(mem_wren),  64'(0));
    check_perf("rst");
    init_mem  = 1'b0;
    req_valid = 2'b00;
    @(negedge clock);
    rst = 1'b0;

    // Single read of a known word
    drive(2'b01, 2'b00, 2'b00, 5, 0, 0, 0);
    check("sr_rden", 64'(cap_rden), 64'(1));
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    check("sr_rsp_valid", 64'(cap_rv), 64'(2'b01));
    check("sr_rsp_data",  64'(cap_rd), 64'(32'hDEADBEEF));

    // Contention from reset: alternating grants, responses to own requester
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(2'b11, 2'b00, 2'b00, 8 + k, 16 + k, 0, 0);
      else       drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      if (k < 4) check("cont_grant", 64'(cap_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (k > 0) check("cont_rsp", 64'(cap_rv), (k % 2 == 1) ? 64'(2'b01) : 64'(2'b10));
    end

    // Lock burst by requester 1 while requester 0 waits
    drive(2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
    drive(2'b11, 2'b00, 2'b10, 2, 20, 0, 0);
    check("burst_g1", 64'(cap_ready), 64'(2'b10));
    drive(2'b11, 2'b00, 2'b10, 2, 21, 0, 0);
    check("burst_g2", 64'(cap_ready), 64'(2'b10));
    drive(2'b11, 2'b00, 2'b00, 2, 22, 0, 0);
    check("burst_g3", 64'(cap_ready), 64'(2'b10));
    drive(2'b01, 2'b00, 2'b00, 2, 0, 0, 0);
    check("burst_after", 64'(cap_ready), 64'(2'b01));

    // Lock drop: owner deasserts valid, other requester wins next cycle
    drive(2'b01, 2'b00, 2'b00, 4, 0, 0, 0);
    drive(2'b11, 2'b00, 2'b10, 4, 30, 0, 0);
    check("drop_lock", 64'(cap_ready), 64'(2'b10));
    drive(2'b01, 2'b00, 2'b00, 4, 0, 0, 0);
    check("drop_hold", 64'(cap_ready), 64'(2'b00));
    drive(2'b01, 2'b00, 2'b00, 4, 0, 0, 0);
    check("drop_grant0", 64'(cap_ready), 64'(2'b01));

    // Write then read the same word
    drive(2'b01, 2'b01, 2'b00, 3, 0, 32'h12345678, 0);
    drive(2'b01, 2'b00, 2'b00, 3, 0, 0, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    check("wr_rd_data", 64'(cap_rd), 64'(32'h12345678));

    // Asynchronous reset while a read response is pending
    drive(2'b11, 2'b00, 2'b00, 5, 6, 0, 0);
    #2;
    rst       = 1'b1;
    req_valid = 2'b00;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("arst_rsp_data",  64'(rsp_data),  64'(0));
    model_reset();
    check_perf("arst");
    @(negedge clock);
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    check("arst_no_rsp", 64'(cap_rv), 64'(0));

    // Randomized traffic, honouring the hold-while-stalled rule
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (!stalled[i]) begin
          req_valid[i]   = ($urandom_range(0, 9) < 7);
          req_wr[i]      = ($urandom_range(0, 2) == 0);
          req_lock[i]    = ($urandom_range(0, 3) == 0);
          req_address[i] = AW'($urandom_range(0, 7));
          req_data[i]    = $urandom;
        end
      end
      step();
    end
    check_perf("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
